// File: rtl/wb_switch_param.sv
// Wishbone 1-master / NSLAVES-slave switch: mask/match address decode, registered slave bus, one transfer at a time.
// Define WB_SWITCH_TIMEOUT_EN to build the bus watchdog (TOUT state, tmo_o pulse, saturating tmo_cnt_o).
module wb_switch_param #(
    parameter int                    NSLAVES = 10,
    parameter logic [NSLAVES*20-1:0] ADDR    = '0,
    parameter logic [NSLAVES*20-1:0] MASK    = '0,
    parameter int                    TIMEOUT = 256
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [15:0]           m_dat_i,
    output logic [15:0]           m_dat_o,
    input  logic [20:1]           m_adr_i,
    input  logic [1:0]            m_sel_i,
    input  logic                  m_we_i,
    input  logic                  m_cyc_i,
    input  logic                  m_stb_i,
    output logic                  m_ack_o,
    output logic [15:0]           s_dat_o,
    output logic [20:1]           s_adr_o,
    output logic [1:0]            s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    input  logic [NSLAVES*16-1:0] s_dat_i,
    input  logic [NSLAVES-1:0]    s_ack_i,
    output logic [NSLAVES-1:0]    s_stb_o,
    output logic                  tmo_o,
    output logic [7:0]            tmo_cnt_o
);
    localparam int                  IW      = $clog2(NSLAVES);
    localparam logic [NSLAVES-1:0]  STB_ONE = 1;

    if (NSLAVES < 2 || NSLAVES > 16 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("wb_switch_param: NSLAVES or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   slv_q, slv_d, dec_idx;
    logic [20:1]     adr_q, adr_d;
    logic [1:0]      sel_q, sel_d;
    logic [15:0]     dat_q, dat_d;
    logic            we_q, we_d;
    logic            slv_ack;
    logic [15:0]     slv_dat;
    logic            start;

`ifdef WB_SWITCH_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0]     wd_q, wd_d;
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;
`endif

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        dec_idx = IW'(NSLAVES - 1);
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (MASK[i*20 +: 20] == 20'h0 || (m_adr_i & MASK[i*20 +: 20]) == ADDR[i*20 +: 20])
                dec_idx = IW'(i);
        end
    end

    assign start   = (state_q == IDLE) && m_cyc_i && m_stb_i;
    assign slv_ack = s_ack_i[slv_q];
    assign slv_dat = s_dat_i[{slv_q, 4'b0000} +: 16];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (m_cyc_i && m_stb_i) state_d = BUSY;
            BUSY: begin
                if (!m_cyc_i || slv_ack) state_d = IDLE;
`ifdef WB_SWITCH_TIMEOUT_EN
                else if (wd_q == WD_LAST) state_d = TOUT;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Acks during an abort cycle are masked so a dropped cycle never completes.
    always_comb begin
        m_ack_o = 1'b0;
        m_dat_o = 16'h0;
        s_stb_o = '0;
        s_cyc_o = 1'b0;
        tmo_o   = 1'b0;
        case (state_q)
            BUSY: begin
                s_stb_o = STB_ONE << slv_q;
                s_cyc_o = 1'b1;
                m_ack_o = m_cyc_i & slv_ack;
                m_dat_o = slv_dat;
            end
`ifdef WB_SWITCH_TIMEOUT_EN
            TOUT: begin
                m_ack_o = 1'b1;
                m_dat_o = 16'hFFFF;
                tmo_o   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        slv_d = slv_q;
        adr_d = adr_q;
        sel_d = sel_q;
        dat_d = dat_q;
        we_d  = we_q;
        if (start) begin
            slv_d = dec_idx;
            adr_d = m_adr_i;
            sel_d = m_sel_i;
            dat_d = m_dat_i;
            we_d  = m_we_i;
        end
    end

`ifdef WB_SWITCH_TIMEOUT_EN
    always_comb begin
        wd_d      = wd_q;
        tmo_cnt_d = tmo_cnt_q;
        if (start) begin
            wd_d = 16'h0;
        end else if (state_q == BUSY && m_cyc_i && !slv_ack && wd_q != WD_LAST) begin
            wd_d = wd_q + 16'd1;
        end
        if (state_q == BUSY && state_d == TOUT && tmo_cnt_q != 8'hFF)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_q      <= 16'h0;
            tmo_cnt_q <= 8'h0;
        end else begin
            wd_q      <= wd_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_cnt_o = tmo_cnt_q;
`else
    assign tmo_cnt_o = 8'h0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            slv_q <= '0;
            adr_q <= '0;
            sel_q <= 2'b00;
            dat_q <= 16'h0;
            we_q  <= 1'b0;
        end else begin
            slv_q <= slv_d;
            adr_q <= adr_d;
            sel_q <= sel_d;
            dat_q <= dat_d;
            we_q  <= we_d;
        end
    end

    assign s_adr_o = adr_q;
    assign s_sel_o = sel_q;
    assign s_dat_o = dat_q;
    assign s_we_o  = we_q;

endmodule
